// File: rtl/ahbl_sram_adapter.sv
// AHB-Lite subordinate for a single-ported synchronous SRAM, zero wait states.
// A one-entry write buffer resolves read/write port collisions; reads merge pending bytes.
module ahbl_sram_adapter #(
  parameter int W_ADDR = 32,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ahbls_hready,
  output logic                     ahbls_hready_resp,
  output logic                     ahbls_hresp,
  input  logic [W_ADDR-1:0]        ahbls_haddr,
  input  logic                     ahbls_hwrite,
  input  logic [1:0]               ahbls_htrans,
  input  logic [2:0]               ahbls_hsize,
  input  logic [31:0]              ahbls_hwdata,
  output logic [31:0]              ahbls_hrdata,
  output logic                     sram_cs_n,
  output logic                     sram_we_n,
  output logic [3:0]               sram_be_n,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [31:0]              sram_wdata,
  input  logic [31:0]              sram_rdata
);

  localparam int AW = $clog2(DEPTH);

  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] base, input logic [31:0] upd,
                                              input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = sel[i] ? upd[8*i +: 8] : base[8*i +: 8];
    return r;
  endfunction

  logic          rd_dph, wr_dph;
  logic [AW-1:0] dph_addr;
  logic [3:0]    dph_mask;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [3:0]    wb_mask;
  logic [31:0]   wb_data;

  logic          aphase, rd_acc, wr_go, wb_load, wb_drain, wb_hit;
  logic [AW-1:0] a_word;

  wire unused_bits = &{1'b0, ahbls_haddr[W_ADDR-1:AW+2], ahbls_htrans[0]};

  // Address phase decode; nothing is accepted while reset is held so the SRAM stays idle.
  assign aphase   = rst_n && ahbls_hready && ahbls_htrans[1];
  assign rd_acc   = aphase && !ahbls_hwrite;
  assign wr_go    = wr_dph && ahbls_hready;
  assign wb_load  = rd_acc && wr_go;
  assign wb_drain = !rd_acc && !wr_go && wb_valid;
  assign a_word   = ahbls_haddr[AW+1:2];

  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;

  always_comb begin
    sram_cs_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = 4'hf;
    sram_addr  = a_word;
    sram_wdata = wb_data;
    if (rd_acc) begin
      sram_cs_n = 1'b0;
    end else if (wr_go) begin
      sram_cs_n  = 1'b0;
      sram_we_n  = 1'b0;
      sram_be_n  = ~dph_mask;
      sram_addr  = dph_addr;
      sram_wdata = ahbls_hwdata;
    end else if (wb_valid) begin
      sram_cs_n = 1'b0;
      sram_we_n = 1'b0;
      sram_be_n = ~wb_mask;
      sram_addr = wb_addr;
    end
  end

  // The buffer stays visible to reads during its drain cycle.
  assign wb_hit       = wb_valid && (wb_addr == dph_addr);
  assign ahbls_hrdata = rd_dph ? merge_bytes(sram_rdata, wb_data, wb_hit ? wb_mask : 4'h0)
                               : 32'h0;

  // Data-phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dph   <= 1'b0;
      wr_dph   <= 1'b0;
      dph_addr <= '0;
      dph_mask <= '0;
    end else if (ahbls_hready) begin
      if (aphase) begin
        rd_dph   <= !ahbls_hwrite;
        wr_dph   <= ahbls_hwrite;
        dph_addr <= a_word;
        dph_mask <= byte_mask(ahbls_hsize, ahbls_haddr[1:0]);
      end else begin
        rd_dph   <= 1'b0;
        wr_dph   <= 1'b0;
        dph_addr <= '0;
        dph_mask <= '0;
      end
    end
  end

  // Write buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_mask  <= '0;
      wb_data  <= '0;
    end else if (wb_load) begin
      wb_valid <= 1'b1;
      wb_addr  <= dph_addr;
      wb_mask  <= dph_mask;
      wb_data  <= ahbls_hwdata;
    end else if (wb_drain) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_adapter.sv
// Randomized scoreboard bench for ahbl_sram_adapter: a word-array reference model
// predicts read data, a behavioural SRAM sits on the memory port.
module tb_ahbl_sram_adapter;

  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ahbls_hready;
  logic          ahbls_hready_resp;
  logic          ahbls_hresp;
  logic [31:0]   ahbls_haddr;
  logic          ahbls_hwrite;
  logic [1:0]    ahbls_htrans;
  logic [2:0]    ahbls_hsize;
  logic [31:0]   ahbls_hwdata;
  logic [31:0]   ahbls_hrdata;
  logic          sram_cs_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  ahbl_sram_adapter #(.W_ADDR(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_hready(ahbls_hready), .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp(ahbls_hresp), .ahbls_haddr(ahbls_haddr), .ahbls_hwrite(ahbls_hwrite),
    .ahbls_htrans(ahbls_htrans), .ahbls_hsize(ahbls_hsize), .ahbls_hwdata(ahbls_hwdata),
    .ahbls_hrdata(ahbls_hrdata), .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int bad_writes = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural synchronous SRAM
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  always @(posedge clk)
    if (!rst_n && !sram_cs_n && !sram_we_n) bad_writes++;

  // Reference model: memory image updated in transaction order
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] exp_q[$];
  logic [31:0] next_wdata;

  function automatic int word_of(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n, off, w;
    n   = (sz >= 3'd2) ? 4 : (1 << sz);
    off = int'(a[1:0]) & ~(n - 1);
    w   = word_of(a);
    for (int i = off; i < off + n; i++) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
  endtask

  // Scoreboard monitor: tracks read data phases from the bus side
  logic rd_next;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_next <= 1'b0;
    else        rd_next <= ahbls_hready && ahbls_htrans[1] && !ahbls_hwrite;

  always @(negedge clk) begin
    check("hready_resp", {31'b0, ahbls_hready_resp}, 32'h1);
    if (rd_next) begin
      if (exp_q.size() == 0) check("unexpected_read", ahbls_hrdata, 32'hx);
      else check("hrdata", ahbls_hrdata, exp_q.pop_front());
    end else begin
      check("hrdata_idle", ahbls_hrdata, 32'h0);
    end
  end

  // One bus cycle: address phase of a new transfer plus data for the previous write
  task automatic xfer(input logic act, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic be_chk, input logic [3:0] be_exp);
    ahbls_hready = 1'b1;
    ahbls_hwdata = next_wdata;
    ahbls_htrans = act ? 2'b10 : 2'b00;
    ahbls_hwrite = wr;
    ahbls_haddr  = a;
    ahbls_hsize  = sz;
    next_wdata   = $urandom;
    if (act && wr) begin
      ref_write(a, sz, wd);
      next_wdata = wd;
    end else if (act) begin
      exp_q.push_back(ref_mem[word_of(a)]);
    end
    if (be_chk) begin
      #1;
      check("sram_be_n", {28'b0, sram_be_n}, {28'b0, be_exp});
      check("sram_we_n", {31'b0, sram_we_n}, 32'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr_t(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    xfer(1'b1, 1'b1, a, sz, d, 1'b0, 4'h0);
  endtask
  task automatic rd_t(input logic [31:0] a);
    xfer(1'b1, 1'b0, a, 3'd2, 32'h0, 1'b0, 4'h0);
  endtask
  task automatic idle_t();
    xfer(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 4'h0);
  endtask
  task automatic idle_be(input logic [3:0] be);
    xfer(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, be);
  endtask

  // Another subordinate stalls: an active-looking transfer must be ignored
  task automatic stall_t();
    ahbls_hready = 1'b0;
    ahbls_htrans = 2'b10;
    ahbls_hwrite = 1'($urandom);
    ahbls_haddr  = $urandom;
    ahbls_hwdata = $urandom;
    @(posedge clk); #1;
    ahbls_hready = 1'b1;
    ahbls_htrans = 2'b00;
  endtask

  initial begin
    logic [31:0] a, d;
    int r;
    rst_n = 1'b0;
    ahbls_hready = 1'b1; ahbls_haddr = '0; ahbls_hwrite = 1'b0;
    ahbls_htrans = 2'b00; ahbls_hsize = 3'd0; ahbls_hwdata = '0;
    next_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hrdata", ahbls_hrdata, 32'h0);
    check("rst_cs_n", {31'b0, sram_cs_n}, 32'h1);
    check("rst_we_n", {31'b0, sram_we_n}, 32'h1);
    check("rst_be_n", {28'b0, sram_be_n}, 32'hf);
    check("rst_hresp", {31'b0, ahbls_hresp}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload the 32 words used by the bench, back to back
    for (int i = 0; i < 32; i++) wr_t(i * 4, 3'd2, $urandom);
    idle_t();

    // Word write, idle, read
    wr_t(32'h10, 3'd2, 32'hdeadbeef); idle_t(); rd_t(32'h10); idle_t();

    // Byte write into lane 3
    wr_t(32'h10, 3'd2, 32'h11223344); idle_t();
    wr_t(32'h13, 3'd0, 32'hAA000000); idle_be(4'b0111);
    rd_t(32'h10); idle_t();

    // Write then read same word: buffered, merged, drained on the next free cycle
    wr_t(32'h20, 3'd2, 32'h55667788); rd_t(32'h20); idle_be(4'b0000); idle_t();
    rd_t(32'h20); idle_t();

    // Buffer held through several reads, final read merges, single drain
    wr_t(32'h20, 3'd2, 32'h0badf00d); rd_t(32'h24); rd_t(32'h28); rd_t(32'h20);
    idle_be(4'b0000); idle_t(); rd_t(32'h20); idle_t();

    // Read followed by write to the same word
    wr_t(32'h30, 3'd2, 32'h77777777); idle_t();
    rd_t(32'h30); wr_t(32'h30, 3'd2, 32'h1); rd_t(32'h30); idle_t(); rd_t(32'h30); idle_t();

    // Reset while the buffer is holding a write
    wr_t(32'h40, 3'd2, 32'hcafef00d); idle_t();
    wr_t(32'h40, 3'd2, 32'h12345678); rd_t(32'h44);
    ahbls_htrans = 2'b00;
    rst_n = 1'b0;
    #1;
    check("rstmid_hrdata", ahbls_hrdata, 32'h0);
    check("rstmid_hready_resp", {31'b0, ahbls_hready_resp}, 32'h1);
    check("rstmid_cs_n", {31'b0, sram_cs_n}, 32'h1);
    exp_q.delete();
    ref_mem[word_of(32'h40)] = 32'hcafef00d;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_t(); rd_t(32'h40); rd_t(32'h44); idle_t();

    // Randomized traffic over 32 words with aliased upper address bits
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFFF800) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      d = $urandom;
      if (r <= 3)      rd_t(a);
      else if (r <= 7) wr_t(a, 3'($urandom_range(0, 4)), d);
      else if (r == 8) idle_t();
      else begin idle_t(); stall_t(); end
    end
    idle_t(); idle_t(); idle_t();

    check("queue_empty", exp_q.size(), 32'h0);
    check("writes_in_reset", bad_writes, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
